// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit: eight selectable two-operand operations, plus a burst mode
// that folds a stream of operands into one result behind a valid/ready handshake.
module logic_unit_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             acc_mode,
  input  logic             last,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             ones,
  output logic [7:0]       beats
);

  typedef enum logic {S_IDLE, S_ACCUM} state_t;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_ANDN = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_XNOR = 3'b110;

  function automatic logic [WIDTH-1:0] logic_op(input logic [2:0]       sel,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (sel)
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      OP_ANDN: r = x & ~y;
      OP_NAND: r = ~(x & y);
      OP_NOR:  r = ~(x | y);
      OP_XNOR: r = ~(x ^ y);
      default: r = x;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [2:0]       op_l_q, op_l_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [7:0]       beats_q, beats_d;
  logic             vld_q, vld_d;
  logic             accept;
  logic [WIDTH-1:0] fold;
  logic [7:0]       cnt_inc;

  assign in_ready = !vld_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign fold     = logic_op(op_l_q, acc_q, a);
  assign cnt_inc  = sat_inc(cnt_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      op_l_q  <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      beats_q <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      op_l_q  <= op_l_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      beats_q <= beats_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    op_l_d  = op_l_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    beats_d = beats_q;
    vld_d   = vld_q && !out_ready;
    if (accept) begin
      case (state_q)
        S_IDLE: begin
          // A length-1 burst is indistinguishable from a single-mode beat.
          if (!acc_mode || last) begin
            out_d   = logic_op(op, a, b);
            beats_d = 8'd1;
            vld_d   = 1'b1;
          end else begin
            acc_d   = logic_op(op, a, b);
            op_l_d  = op;
            cnt_d   = 8'd1;
            state_d = S_ACCUM;
          end
        end
        default: begin
          acc_d = fold;
          cnt_d = cnt_inc;
          if (last) begin
            out_d   = fold;
            beats_d = cnt_inc;
            vld_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      endcase
    end
  end

  assign out_valid = vld_q;
  assign out       = out_q;
  assign beats     = beats_q;
  assign zero      = (out_q == '0);
  assign ones      = &out_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: directed scenarios plus randomized traffic against a
// truth-table reference model of the unit's handshake and burst behaviour.
module tb_logic_unit_pipe;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, acc_mode, last, out_valid, out_ready, zero, ones;
  logic [2:0]   op;
  logic [W-1:0] a, b, out;
  logic [7:0]   beats;
  int           n_cmp = 0;
  int           n_bad = 0;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .acc_mode(acc_mode), .last(last), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .zero(zero), .ones(ones), .beats(beats)
  );

  // Reference: each op is a 4-entry truth table indexed by {x_bit, y_bit}.
  function automatic logic [W-1:0] ref_f(input logic [2:0] sel, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    logic [3:0]   tt;
    logic [W-1:0] r;
    case (sel)
      3'd0: tt = 4'b1000;
      3'd1: tt = 4'b1110;
      3'd2: tt = 4'b0110;
      3'd3: tt = 4'b0100;
      3'd4: tt = 4'b0111;
      3'd5: tt = 4'b0001;
      3'd6: tt = 4'b1001;
      default: tt = 4'b1100;
    endcase
    for (int i = 0; i < W; i++) r[i] = tt[{x[i], y[i]}];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic am, input logic l,
                       input logic [W-1:0] aa, input logic [W-1:0] bb);
    in_valid = v; op = o; acc_mode = am; last = l; a = aa; b = bb;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; out_ready = 1'b0;
    drive(1'b1, 3'd1, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF);
    step(); step();
    rst = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_cmp++; if (out !== 16'h0) begin n_bad++; $display("FAIL reset_out got %h want 0000", out); end
    n_cmp++; if (beats !== 8'd0) begin n_bad++; $display("FAIL reset_beats got %0d want 0", beats); end
    n_cmp++; if (zero !== 1'b1 || ones !== 1'b0) begin n_bad++; $display("FAIL reset_flags got z%b o%b want z1 o0", zero, ones); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", in_ready); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_nocapture got %b want 0", out_valid); end
  endtask

  task automatic test_single_and();
    drive(1'b1, 3'd0, 1'b0, 1'b0, 16'hF0F0, 16'h3C3C);
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out !== 16'h3030) begin n_bad++; $display("FAIL and_out got v%b %h want v1 3030", out_valid, out); end
    n_cmp++; if (beats !== 8'd1 || zero !== 1'b0 || ones !== 1'b0) begin n_bad++; $display("FAIL and_meta got b%0d z%b o%b want b1 z0 o0", beats, zero, ones); end
    out_ready = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL and_drain got %b want 0", out_valid); end
  endtask

  task automatic test_op_sweep();
    logic [W-1:0] exp_tab [8];
    exp_tab = '{16'hAAAA, 16'hFFFF, 16'h5555, 16'h0000, 16'h5555, 16'h0000, 16'hAAAA, 16'hAAAA};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(i), 1'b0, 1'b0, 16'hAAAA, 16'hFFFF);
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || out !== exp_tab[i] || zero !== (exp_tab[i] == 16'h0) || beats !== 8'd1) begin
        n_bad++; $display("FAIL sweep_op%0d got v%b %h z%b b%0d want v1 %h", i, out_valid, out, zero, beats, exp_tab[i]);
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_or_burst();
    out_ready = 1'b1;
    drive(1'b1, 3'd1, 1'b1, 1'b0, 16'h0001, 16'h0000);
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL burst_early1 got %b want 0", out_valid); end
    drive(1'b1, 3'd0, 1'b0, 1'b0, 16'h0010, 16'hFFFF);
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL burst_early2 got %b want 0", out_valid); end
    drive(1'b1, 3'd0, 1'b0, 1'b1, 16'h0100, 16'h0000);
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out !== 16'h0111 || beats !== 8'd3) begin n_bad++; $display("FAIL burst_result got v%b %h b%0d want v1 0111 b3", out_valid, out, beats); end
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 3'd7, 1'b0, 1'b0, 16'h1234, 16'h0000);
    step();
    drive(1'b1, 3'd7, 1'b0, 1'b0, 16'h5678, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out !== 16'h1234 || beats !== 8'd1) begin
        n_bad++; $display("FAIL bp_hold%0d got r%b v%b %h b%0d want r0 v1 1234 b1", i, in_ready, out_valid, out, beats);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out !== 16'h5678) begin n_bad++; $display("FAIL bp_new got v%b %h want v1 5678", out_valid, out); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_burst();
    out_ready = 1'b1;
    drive(1'b1, 3'd1, 1'b1, 1'b0, 16'h000F, 16'h0000);
    step(); step();
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || out !== 16'h0) begin n_bad++; $display("FAIL midrst_out got v%b %h want v0 0000", out_valid, out); end
    drive(1'b1, 3'd2, 1'b0, 1'b0, 16'hFFFF, 16'h0F0F);
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out !== 16'hF0F0 || beats !== 8'd1) begin n_bad++; $display("FAIL midrst_xor got v%b %h b%0d want v1 f0f0 b1", out_valid, out, beats); end
    step();
  endtask

  task automatic test_saturation();
    logic [W-1:0] e;
    out_ready = 1'b1;
    e = '0;
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 3'd1, (i == 0), (i == 299), W'(1) << (i % W), 16'h0);
      e = ref_f(3'd1, e, a);
      step();
    end
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || beats !== 8'd255 || out !== e || ones !== 1'b1) begin n_bad++; $display("FAIL sat got v%b b%0d %h o%b want v1 b255 %h o1", out_valid, beats, out, ones, e); end
    step();
  endtask

  task automatic test_random();
    logic         exp_vld, open, acc;
    logic [W-1:0] exp_out, pacc, r;
    logic [7:0]   exp_beats;
    logic [2:0]   pop;
    int           pcnt;
    exp_vld = 1'b0; exp_out = out; exp_beats = beats; open = 1'b0; pacc = '0; pop = '0; pcnt = 0;
    for (int c = 0; c < 600; c++) begin
      n_cmp++;
      if (out_valid !== exp_vld || (exp_vld && (out !== exp_out || beats !== exp_beats ||
          zero !== (exp_out == '0) || ones !== (exp_out == '1)))) begin
        n_bad++; $display("FAIL rand_c%0d got v%b %h b%0d z%b o%b want v%b %h b%0d", c, out_valid, out, beats, zero, ones, exp_vld, exp_out, exp_beats);
      end
      drive($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), $urandom_range(0, 9) < 4,
            $urandom_range(0, 9) < 3, W'($urandom), W'($urandom));
      out_ready = $urandom_range(0, 9) < 6;
      #1;
      n_cmp++;
      if (in_ready !== (!exp_vld || out_ready)) begin n_bad++; $display("FAIL rand_ready_c%0d got %b want %b", c, in_ready, !exp_vld || out_ready); end
      acc = in_valid && (!exp_vld || out_ready);
      if (exp_vld && out_ready) exp_vld = 1'b0;
      if (acc) begin
        if (!open) begin
          r = ref_f(op, a, b);
          if (!acc_mode || last) begin
            exp_out = r; exp_beats = 8'd1; exp_vld = 1'b1;
          end else begin
            open = 1'b1; pacc = r; pop = op; pcnt = 1;
          end
        end else begin
          pacc = ref_f(pop, pacc, a);
          pcnt = (pcnt + 1 > 255) ? 255 : pcnt + 1;
          if (last) begin
            exp_out = pacc; exp_beats = 8'(pcnt); exp_vld = 1'b1; open = 1'b0;
          end
        end
      end
      step();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b0;
    drive(1'b0, 3'd0, 1'b0, 1'b0, '0, '0);
    test_reset();
    test_single_and();
    test_op_sweep();
    test_or_burst();
    test_backpressure();
    test_reset_mid_burst();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
